// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL): one capture register, then one
// registered stage per shift-amount bit. Tags ride along with each operation.
module shift_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_zero
);

  localparam int DEPTH = SHAMT_W + 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // Slot 0 holds the raw operand; slot k+1 holds the result after shift stage k.
  logic               vld_p   [DEPTH];
  logic [WIDTH-1:0]   data_p  [DEPTH];
  logic [SHAMT_W-1:0] shamt_p [DEPTH];
  logic [1:0]         op_p    [DEPTH];
  logic [TAG_W-1:0]   tag_p   [DEPTH];
  logic               sign_p  [DEPTH];

  logic stall;

  // The SRA fill comes from the operand's original sign bit, carried per slot.
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             sign,
    input logic             en,
    input int unsigned      amt
  );
    logic [WIDTH-1:0] res;
    res = d;
    if (en) begin
      case (op)
        OP_SLL:  res = d << amt;
        OP_SRL:  res = d >> amt;
        OP_SRA:  res = (d >> amt) | (sign ? ~({WIDTH{1'b1}} >> amt) : '0);
        default: res = (d << amt) | (d >> (WIDTH - amt));
      endcase
    end
    return res;
  endfunction

  assign stall    = vld_p[DEPTH-1] & ~out_ready;
  assign in_ready = ~stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        vld_p[k]   <= 1'b0;
        data_p[k]  <= '0;
        shamt_p[k] <= '0;
        op_p[k]    <= '0;
        tag_p[k]   <= '0;
        sign_p[k]  <= 1'b0;
      end
    end else if (!stall) begin
      // capture stage: bubbles enter here whenever in_valid is low
      vld_p[0]   <= in_valid;
      data_p[0]  <= in_data;
      shamt_p[0] <= in_shamt;
      op_p[0]    <= in_op;
      tag_p[0]   <= in_tag;
      sign_p[0]  <= in_data[WIDTH-1];
      // shift stage k: consumes the low remaining shamt bit, shifts by 2^k
      for (int k = 0; k < SHAMT_W; k++) begin
        vld_p[k+1]   <= vld_p[k];
        data_p[k+1]  <= shift_stage(data_p[k], op_p[k], sign_p[k], shamt_p[k][0],
                                    int'(unsigned'(1) << k));
        shamt_p[k+1] <= shamt_p[k] >> 1;
        op_p[k+1]    <= op_p[k];
        tag_p[k+1]   <= tag_p[k];
        sign_p[k+1]  <= sign_p[k];
      end
    end
  end

  // output stage
  assign out_valid = vld_p[DEPTH-1];
  assign out_data  = data_p[DEPTH-1];
  assign out_tag   = tag_p[DEPTH-1];
  assign out_zero  = (data_p[DEPTH-1] == '0);

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the ALU/execute path.
- Supports four modes: logical left, logical right, arithmetic right and rotate left.
- Uses log2(WIDTH) shift stages, with a register after each stage and valid/ready handshakes on both sides.
- Carries a caller tag alongside each operation so writeback can match results to issuing instructions.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two and at least 2.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).
- TAG_W, 5, width of the opaque tag carried with each operation.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation presented on in_* this cycle
- in_ready  output  1  shifter accepts an operation this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
- in_op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL
- in_tag  input  TAG_W  tag, returned unchanged
- out_valid  output  1  result present on out_*
- out_ready  input  1  consumer takes the result this cycle
- out_data  output  WIDTH  shifted result
- out_tag  output  TAG_W  tag of the result
- out_zero  output  1  high when out_data == 0

Behaviour:
- Reset is synchronous and active-high.
  - On any clock edge with reset=1, every stage valid bit, data register and tag register clears to 0.
  - After reset: out_valid=0, out_data=0, out_tag=0, out_zero=1.
  - in_ready reads 1 from the first cycle after reset deasserts.
- Reset mid-operation: all in-flight operations are discarded with no output, and an operation presented during the reset cycle is not accepted.
- Pipeline structure: SHAMT_W stages. Stage k (k=0..SHAMT_W-1) shifts by 2^k when shamt bit k is set, otherwise it passes the value through.
- Each stage registers:
  - valid
  - data
  - remaining shamt bits
  - op
  - tag
- Latency: an operation accepted at edge N appears on out_* after edge N+SHAMT_W when no stall occurs (5 cycles at the defaults). Throughput is one operation per cycle.
- Fill value per mode:
  - SLL: zeros enter at the LSB.
  - SRL: zeros enter at the MSB.
  - SRA: the original operand MSB enters at the MSB. The sign bit is carried through the stages, not re-read from the partial result.
  - ROL: bits leaving the MSB re-enter at the LSB.
- Shift-amount edge cases:
  - shamt=0: the result equals the operand in all modes.
  - shamt=WIDTH-1 is legal.
  - Amounts of WIDTH or more cannot be encoded.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall; this is combinational from out_ready and intentional.
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
- Stall behaviour: while stall=1, every stage register holds, including bubbles, and out_* stays stable.
- Bubbles are not compressed under stall. A bubble ahead of a valid entry advances only when stall=0.
- in_valid=0 while in_ready=1 inserts a bubble (valid=0) into stage 0.
- out_zero is derived combinationally from the registered out_data and is meaningful only when out_valid=1.
- Ordering: results leave in acceptance order. There is no reordering and no drop except at reset.
- Simultaneous out transfer and in transfer in the same cycle: both occur and the pipeline advances one slot.

Test Plan:
- Reset check: assert reset for 2 cycles with in_valid=1 → out_valid=0, out_data=0, out_zero=1. No result ever emerges for the operation presented during reset.
- SLL and SRL: data=0x0000_00F1, shamt=4, op=00, tag=3 → after 5 cycles, out_data=0x0000_0F10, out_tag=3. Then data=0x8000_0000, shamt=31, op=01 → out_data=0x0000_0001.
- SRA and ROL: data=0xF000_0000, shamt=4, op=10 → 0xFF00_0000. Data=0x8000_0001, shamt=1, op=11 → 0x0000_0003. Data=0x7FFF_FFFF, shamt=31, op=10 → 0x0000_0000 with out_zero=1.
- Throughput: 8 back-to-back operations with tags 0..7 and out_ready=1 → results on 8 consecutive cycles starting 5 cycles after the first accept, tags in order 0..7.
- Backpressure: a stream of 4 operations with out_ready=0 for 3 cycles once out_valid rises → in_ready=0 and out_data/out_tag held for those 3 cycles. Release gives all 4 results with none lost or duplicated.
- Mid-flight reset: accept 3 operations, assert reset for 1 cycle at the second cycle after the first accept → no out_valid for those operations. A new operation after reset completes with the correct 5-cycle latency.
